// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path: FSM state encoding,
// byte width and the bit-period calculation.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_rx_state_e;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous receive FIFO with a registered head-of-queue output.
// Same-cycle push and pop are both honoured, even when full.
module uart_rx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [AW:0]      count, count_nxt;
  logic [WIDTH-1:0] head_nxt;
  logic             push_ok, pop_ok;

  assign full_o  = (count == (AW+1)'(DEPTH));
  assign empty_o = (count == '0);
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  // The new head may be the word being written this cycle, so bypass it.
  always_comb begin
    rd_ptr_nxt = pop_ok ? rd_ptr + AW'(1) : rd_ptr;
    count_nxt  = count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    head_nxt   = (push_ok && (rd_ptr_nxt == wr_ptr)) ? wdata_i : mem[rd_ptr_nxt];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head_o <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_ptr_nxt;
      count  <= count_nxt;
      if (count_nxt != '0) head_o <= head_nxt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr] <= wdata_i;
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchroniser, bit-timing FSM and receive FIFO with
// sticky error flags. Define UART_RX_PARITY_EN to add a parity bit check.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 8
`ifdef UART_RX_PARITY_EN
  , parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   rx_i,
  output logic [UART_DATA_W-1:0] data_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic                   frame_err_o,
  output logic                   overrun_err_o,
  output logic                   parity_err_o,
  input  logic                   err_clr_i,
  output logic                   busy_o
);

  localparam int CPB   = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int CNT_W = $clog2(CPB);
  localparam int BIT_W = $clog2(UART_DATA_W);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CPB / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CPB - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(UART_DATA_W - 1);

  logic                   rx_p0, rx_s;
  uart_rx_state_e         state, state_nxt;
  logic [CNT_W-1:0]       cnt, cnt_nxt;
  logic [BIT_W-1:0]       bit_idx, bit_idx_nxt;
  logic [UART_DATA_W-1:0] shreg;
  logic                   shift_en, push, frame_set, overrun_set;
  logic                   fifo_full, fifo_empty;
`ifdef UART_RX_PARITY_EN
  logic                   parity_set, parity_err;
`endif

  // Synchroniser: rx_s lags rx_i by two cycles and idles high.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_p0 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      rx_p0 <= rx_i;
      rx_s  <= rx_p0;
    end
  end

  // Bit timing: start bit checked at half period, later bits one period on.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt + CNT_W'(1);
    bit_idx_nxt = bit_idx;
    shift_en    = 1'b0;
    push        = 1'b0;
    frame_set   = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_set  = 1'b0;
`endif
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (!rx_s) state_nxt = START;
      end
      START: begin
        if (cnt == CNT_HALF) begin
          cnt_nxt     = '0;
          bit_idx_nxt = '0;
          state_nxt   = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == CNT_FULL) begin
          cnt_nxt     = '0;
          shift_en    = 1'b1;
          bit_idx_nxt = bit_idx + BIT_W'(1);
`ifdef UART_RX_PARITY_EN
          if (bit_idx == BIT_LAST) state_nxt = PARITY;
`else
          if (bit_idx == BIT_LAST) state_nxt = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt == CNT_FULL) begin
          cnt_nxt    = '0;
          state_nxt  = STOP;
          parity_set = (rx_s != ((^shreg) ^ PARITY_ODD));
        end
      end
`endif
      STOP: begin
        if (cnt == CNT_FULL) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
          push      = rx_s;
          frame_set = !rx_s;
        end
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_idx_nxt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (shift_en) shreg <= {rx_s, shreg[UART_DATA_W-1:1]};
  end

  // Byte buffer towards the bus side.
  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .wdata_i (shreg),
    .pop_i   (ready_i),
    .head_o  (data_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign valid_o     = !fifo_empty;
  assign busy_o      = (state != IDLE);
  assign overrun_set = push && fifo_full && !ready_i;

  // Sticky flags: a clear wins over a same-cycle set.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      frame_err_o   <= 1'b0;
      overrun_err_o <= 1'b0;
    end else if (err_clr_i) begin
      frame_err_o   <= 1'b0;
      overrun_err_o <= 1'b0;
    end else begin
      frame_err_o   <= frame_err_o | frame_set;
      overrun_err_o <= overrun_err_o | overrun_set;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk_i) begin
    if (rst_i || err_clr_i) parity_err <= 1'b0;
    else                    parity_err <= parity_err | parity_set;
  end
  assign parity_err_o = parity_err;
`else
  assign parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: serial frames are driven bit by bit and
// received bytes are compared with a transaction-level expectation queue.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int CLK_FREQ = 1000000;
  localparam int BAUD     = 100000;
  localparam int DEPTH    = 4;
  localparam int CPB      = CLK_FREQ / BAUD;

  logic       clk = 1'b0;
  logic       rst_i, rx_i, ready_i, err_clr_i;
  logic [7:0] data_o;
  logic       valid_o, frame_err_o, overrun_err_o, parity_err_o, busy_o;

  int         tests_run = 0;
  int         tests_failed = 0;
  logic [7:0] got[$];
  int         vld_cycles = 0;
  bit         stim_done;

  always #5 clk = ~clk;

  uart_rx #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD_RATE  (BAUD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .rx_i          (rx_i),
    .data_o        (data_o),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .frame_err_o   (frame_err_o),
    .overrun_err_o (overrun_err_o),
    .parity_err_o  (parity_err_o),
    .err_clr_i     (err_clr_i),
    .busy_o        (busy_o)
  );

  // Consumer-side monitor: every accepted byte is recorded in order.
  always @(negedge clk) begin
    if (!rst_i) begin
      if (valid_o) vld_cycles++;
      if (valid_o && ready_i) got.push_back(data_o);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic v);
    rx_i = v;
    tick(CPB);
  endtask

  // Frame on the wire: start, 8 data bits LSB first, [parity], stop.
  task automatic send_raw(input logic [7:0] b, input logic stop_v, input logic par_v);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(par_v);
`endif
    send_bit(stop_v);
    rx_i = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v);
    send_raw(b, stop_v, ^b);
  endtask

  task automatic clear_errors();
    err_clr_i = 1'b1;
    tick(1);
    err_clr_i = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy_o !== 1'b0 && n < 400) begin
      tick(1);
      n++;
    end
    tests_run++;
    if (busy_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_busy_timeout: busy_o=%b required 0", name, busy_o);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1; rx_i = 1'b1; ready_i = 1'b1; err_clr_i = 1'b0;
    tick(3);
    tests_run++;
    if (valid_o !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b required 0", valid_o); end
    tests_run++;
    if (data_o !== 8'h00) begin tests_failed++; $display("FAIL reset_data: got %h required 00", data_o); end
    tests_run++;
    if ({frame_err_o, overrun_err_o, parity_err_o} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b required 000", {frame_err_o, overrun_err_o, parity_err_o});
    end
    tests_run++;
    if (busy_o !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b required 0", busy_o); end
    rst_i = 1'b0;
    tick(2);
  endtask

  task automatic test_single();
    int base = got.size();
    int v0 = vld_cycles;
    send_frame(8'hA5, 1'b1);
    tick(20);
    wait_idle("single");
    tests_run++;
    if (got.size() != base + 1 || got[base] !== 8'hA5) begin
      tests_failed++;
      $display("FAIL single_byte: got %0d bytes (first %h) required 1 byte A5", got.size() - base,
               (got.size() > base) ? got[base] : 8'hxx);
    end
    tests_run++;
    if (vld_cycles - v0 != 1) begin
      tests_failed++;
      $display("FAIL single_valid_pulse: valid for %0d cycles required 1", vld_cycles - v0);
    end
    tests_run++;
    if ({frame_err_o, overrun_err_o, parity_err_o} !== 3'b000) begin
      tests_failed++;
      $display("FAIL single_flags: got %b required 000", {frame_err_o, overrun_err_o, parity_err_o});
    end
  endtask

  task automatic test_frame_err();
    int base = got.size();
    send_frame(8'h5A, 1'b0);
    tick(30);
    wait_idle("frame_err");
    tests_run++;
    if (got.size() != base || valid_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL frame_err_drop: got %0d bytes valid=%b required 0 bytes valid=0", got.size() - base, valid_o);
    end
    tests_run++;
    if (frame_err_o !== 1'b1) begin tests_failed++; $display("FAIL frame_err_set: got %b required 1", frame_err_o); end
    clear_errors();
    tests_run++;
    if (frame_err_o !== 1'b0) begin tests_failed++; $display("FAIL frame_err_clear: got %b required 0", frame_err_o); end
  endtask

  task automatic test_glitch();
    int base = got.size();
    rx_i = 1'b0;
    tick(3);
    rx_i = 1'b1;
    tick(30);
    tests_run++;
    if (busy_o !== 1'b0 || got.size() != base || valid_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL glitch_ignored: busy=%b bytes=%0d valid=%b required 0/0/0", busy_o, got.size() - base, valid_o);
    end
    tests_run++;
    if ({frame_err_o, overrun_err_o, parity_err_o} !== 3'b000) begin
      tests_failed++;
      $display("FAIL glitch_flags: got %b required 000", {frame_err_o, overrun_err_o, parity_err_o});
    end
  endtask

  task automatic test_overrun();
    logic [7:0] sent[$];
    logic [7:0] exp[$];
    bit         exp_ov;
    int         base;
    ready_i = 1'b0;
    for (int b = 1; b <= 6; b++) begin
      send_frame(8'(b), 1'b1);
      sent.push_back(8'(b));
    end
    // Nothing drains, so the FIFO keeps the first DEPTH bytes.
    for (int i = 0; i < sent.size() && i < DEPTH; i++) exp.push_back(sent[i]);
    exp_ov = (sent.size() > DEPTH);
    tick(20);
    tests_run++;
    if (valid_o !== 1'b1 || data_o !== exp[0]) begin
      tests_failed++;
      $display("FAIL overrun_head: valid=%b data=%h required 1/%h", valid_o, data_o, exp[0]);
    end
    tests_run++;
    if (overrun_err_o !== exp_ov) begin
      tests_failed++;
      $display("FAIL overrun_flag: got %b required %b", overrun_err_o, exp_ov);
    end
    tick(15);
    tests_run++;
    if (data_o !== exp[0]) begin tests_failed++; $display("FAIL overrun_hold: got %h required %h", data_o, exp[0]); end
    base = got.size();
    ready_i = 1'b1;
    tick(10);
    tests_run++;
    if (got.size() != base + exp.size()) begin
      tests_failed++;
      $display("FAIL overrun_drain_count: got %0d bytes required %0d", got.size() - base, exp.size());
    end else begin
      for (int i = 0; i < exp.size(); i++) begin
        tests_run++;
        if (got[base+i] !== exp[i]) begin
          tests_failed++;
          $display("FAIL overrun_drain_%0d: got %h required %h", i, got[base+i], exp[i]);
        end
      end
    end
    clear_errors();
    tests_run++;
    if (overrun_err_o !== 1'b0) begin tests_failed++; $display("FAIL overrun_clear: got %b required 0", overrun_err_o); end
  endtask

  task automatic test_reset_mid();
    int base;
    ready_i = 1'b1;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    rst_i = 1'b1;
    tick(1);
    rst_i = 1'b0;
    tests_run++;
    if (valid_o !== 1'b0 || busy_o !== 1'b0 || data_o !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_mid_outputs: valid=%b busy=%b data=%h required 0/0/00", valid_o, busy_o, data_o);
    end
    tests_run++;
    if ({frame_err_o, overrun_err_o, parity_err_o} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_mid_flags: got %b required 000", {frame_err_o, overrun_err_o, parity_err_o});
    end
    rx_i = 1'b1;
    tick(CPB * 8);
    base = got.size();
    send_frame(8'h3C, 1'b1);
    tick(20);
    tests_run++;
    if (got.size() != base + 1 || got[base] !== 8'h3C) begin
      tests_failed++;
      $display("FAIL reset_mid_next: got %0d bytes (first %h) required 1 byte 3C", got.size() - base,
               (got.size() > base) ? got[base] : 8'hxx);
    end
  endtask

  task automatic test_random();
    logic [7:0] exp[$];
    bit         exp_ferr = 1'b0;
    int         base = got.size();
    stim_done = 1'b0;
    fork
      begin
        for (int n = 0; n < 12; n++) begin
          logic [7:0] b = 8'($urandom);
          bit bad = ($urandom_range(0, 4) == 0);
          send_frame(b, !bad);
          if (bad) begin
            exp_ferr = 1'b1;
            tick(20 + $urandom_range(0, 10));
          end else begin
            exp.push_back(b);
            tick($urandom_range(0, 12));
          end
        end
        stim_done = 1'b1;
      end
      begin
        while (!stim_done) begin
          ready_i = ($urandom_range(0, 3) != 0);
          tick(1);
        end
      end
    join
    ready_i = 1'b1;
    tick(30);
    wait_idle("random");
    tests_run++;
    if (got.size() != base + exp.size()) begin
      tests_failed++;
      $display("FAIL random_count: got %0d bytes required %0d", got.size() - base, exp.size());
    end else begin
      for (int i = 0; i < exp.size(); i++) begin
        tests_run++;
        if (got[base+i] !== exp[i]) begin
          tests_failed++;
          $display("FAIL random_byte_%0d: got %h required %h", i, got[base+i], exp[i]);
        end
      end
    end
    tests_run++;
    if (frame_err_o !== exp_ferr || overrun_err_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL random_flags: frame=%b overrun=%b required %b/0", frame_err_o, overrun_err_o, exp_ferr);
    end
    clear_errors();
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int base = got.size();
    ready_i = 1'b1;
    send_raw(8'h07, 1'b1, 1'b0);
    tick(20);
    tests_run++;
    if (got.size() != base + 1 || got[base] !== 8'h07 || parity_err_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL parity_bad: bytes=%0d perr=%b required 1 byte 07 perr=1", got.size() - base, parity_err_o);
    end
    clear_errors();
    base = got.size();
    send_raw(8'h07, 1'b1, 1'b1);
    tick(20);
    tests_run++;
    if (got.size() != base + 1 || got[base] !== 8'h07 || parity_err_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL parity_good: bytes=%0d perr=%b required 1 byte 07 perr=0", got.size() - base, parity_err_o);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_frame_err();
    test_glitch();
    test_overrun();
    test_reset_mid();
    test_random();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver: deserialises the `uart_rx_i` line of the SoC into bytes, then buffers them for the SoC's memory-mapped UART peripheral.
- Sits directly upstream of the UART peripheral, between the top-level pin and the bus register interface.
- Format is 8N1 by default; optional parity. Fixed baud derived from parameters.
- Output is a valid/ready byte stream with sticky error flags.

Parameters:
- CLK_FREQ, 50000000: system clock frequency in Hz.
- BAUD_RATE, 115200: line baud rate; CLKS_PER_BIT = CLK_FREQ / BAUD_RATE (integer division, must be >= 4).
- FIFO_DEPTH, 8: receive FIFO entries; power of two, >= 2.

Ports:
- clk_i, input, 1: system clock.
- rst_i, input, 1: synchronous active-high reset.
- rx_i, input, 1: asynchronous serial line, idle high.
- data_o, output, 8: head-of-FIFO byte.
- valid_o, output, 1: FIFO not empty.
- ready_i, input, 1: consumer accepts data_o when valid_o && ready_i.
- frame_err_o, output, 1: sticky; stop bit sampled low.
- overrun_err_o, output, 1: sticky; byte completed while FIFO full.
- parity_err_o, output, 1: sticky parity mismatch; constant 0 without the optional feature.
- err_clr_i, input, 1: clears all sticky flags.
- busy_o, output, 1: FSM not IDLE.

Behaviour:
- Reset: the FSM goes to IDLE and the FIFO empties.
  - valid_o = 0, data_o = 0, all error flags = 0, busy_o = 0.
  - Synchroniser flops reset to 1.
- rx_i passes through a 2-flop synchroniser. All sampling uses the synchronised value rx_s, which is 2 cycles late.
- Bit counter cnt counts 0..CLKS_PER_BIT-1; it is cleared on every state transition.
- FSM states and transitions:
  - IDLE: when rx_s = 0, go to START with cnt = 0.
  - START: at cnt = CLKS_PER_BIT/2 - 1 (mid-bit), check rx_s.
    - rx_s = 1: glitch; return to IDLE and discard.
    - rx_s = 0: go to DATA.
  - DATA: sample at the end of each full period (cnt = CLKS_PER_BIT-1), which is mid-bit after the half-period offset.
    - LSB first; shift into an 8-bit register; bit index counts 0..7.
    - After bit 7, go to PARITY if the optional feature is enabled, else STOP.
  - STOP: sample at the full period.
    - rx_s = 0: set frame_err_o and drop the byte.
    - rx_s = 1: push the byte to the FIFO.
    - Go to IDLE on the same cycle as the sample. The next start bit is therefore detected within the trailing half stop bit.
- FIFO:
  - Push and pop in the same cycle are both honoured, including when the FIFO is full.
  - Push when full with no pop: the byte is dropped, overrun_err_o is set, and contents are unchanged.
  - Pop when empty is ignored.
  - data_o is registered FIFO head; it holds its value while valid_o && !ready_i.
  - First-byte latency: valid_o rises the cycle after the stop-bit sample.
- Sticky flags:
  - err_clr_i takes priority over a same-cycle set, so the flag reads 0 next cycle.
  - A new error in the following cycle sets the flag again.
- Reset mid-frame aborts the frame immediately: the partial byte is discarded and the FIFO is cleared.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds parameter PARITY_ODD (default 0 = even) and FSM state PARITY between DATA and STOP.
  - The parity bit is sampled at the full period.
  - On mismatch, parity_err_o is set, but the byte is still pushed if the stop bit is valid.
- Undefined: no PARITY state, the frame is 10 bits, and parity_err_o is tied 0.

Decomposition:
- Package uart_pkg:
  - FSM state enum uart_rx_state_e (IDLE, START, DATA, PARITY, STOP).
  - localparam function clks_per_bit(clk_freq, baud).
  - UART_DATA_W = 8.
- Sub-module uart_rx_fifo: synchronous FIFO.
  - Parameters: DEPTH, WIDTH.
  - Ports: push/pop handshake, full/empty outputs.
  - Registered output head.

Test Plan (CLK_FREQ=1000000, BAUD_RATE=100000, i.e. CLKS_PER_BIT=10; FIFO_DEPTH=4):
- Single byte 0xA5, 8N1, ready_i=1 -> valid_o pulses for 1 cycle with data_o=0xA5. No error flags are set. busy_o returns low.
- 0x5A as a stop-bit-0 frame -> no valid_o, frame_err_o=1. A subsequent err_clr_i pulse -> frame_err_o=0.
- 3-cycle low glitch on idle line -> returns to IDLE, no byte is produced, no flag is set.
- Six bytes 0x01..0x06 back-to-back, ready_i=0 -> FIFO holds 0x01..0x04 and overrun_err_o=1. Then ready_i=1 -> bytes 0x01, 0x02, 0x03, 0x04 are popped in order.
- rst_i asserted for 1 cycle mid-DATA of byte 0xFF -> outputs return to reset values. The next frame 0x3C is received correctly.
- With UART_RX_PARITY_EN and PARITY_ODD=0: byte 0x07 sent with parity bit 0 -> data_o=0x07 and parity_err_o=1. With parity bit 1 -> parity_err_o stays 0.
